// File: rtl/sprite_pkg.sv
// Shared constants and state type for the sprite blitter.
package sprite_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int IDX_W    = 3;
    localparam int ROM_AW   = 13;
    localparam int FB_AW    = 19;

    localparam logic [IDX_W-1:0] TRANSP_IDX = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_t;
endpackage

// File: rtl/blit_addr_gen.sv
// Raster-order pixel walker: row/col counters, sprite ROM address,
// screen coordinates and the on-screen flag for the pixel currently addressed.
module blit_addr_gen
    import sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    input  logic [6:0]        i_w,
    input  logic [6:0]        i_h,
    input  logic [ROM_AW-1:0] i_base,
    output logic [ROM_AW-1:0] o_rom_addr,
    output logic [FB_AW-1:0]  o_fb_addr,
    output logic              o_on_screen,
    output logic              o_last
);
    logic [9:0]  r_x, r_y;
    logic [6:0]  r_w, r_h;
    logic [6:0]  r_col, r_row;
    logic [10:0] w_sx, w_sy;

    // Latch the command on load, then step col/row and the ROM address one pixel per advance.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_col      <= '0;
            r_row      <= '0;
            o_rom_addr <= '0;
        end else if (i_load) begin
            r_x        <= i_x;
            r_y        <= i_y;
            r_w        <= i_w;
            r_h        <= i_h;
            r_col      <= '0;
            r_row      <= '0;
            o_rom_addr <= i_base;
        end else if (i_advance) begin
            o_rom_addr <= o_rom_addr + 1'b1;
            if (r_col == r_w - 7'd1) begin
                r_col <= '0;
                r_row <= r_row + 7'd1;
            end else begin
                r_col <= r_col + 7'd1;
            end
        end
    end

    // Screen coordinates are 11 bits wide so a sprite hanging off the right/bottom never wraps back on-screen.
    assign w_sx        = {1'b0, r_x} + {4'b0, r_col};
    assign w_sy        = {1'b0, r_y} + {4'b0, r_row};
    assign o_on_screen = (w_sx < 11'(SCREEN_W)) && (w_sy < 11'(SCREEN_H));
    assign o_fb_addr   = FB_AW'(w_sy) * FB_AW'(SCREEN_W) + FB_AW'(w_sx);
    assign o_last      = (r_col == r_w - 7'd1) && (r_row == r_h - 7'd1);
endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: command FSM, two-stage write pipeline with a one-entry
// skid register for the ROM data, and registered frame-buffer write port.
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [6:0]        cmd_w,
    input  logic [6:0]        cmd_h,
    input  logic [ROM_AW-1:0] cmd_base,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [IDX_W-1:0]  fb_data,
    input  logic              fb_stall
);
    blit_state_t      r_state, w_next;
    logic             r_drain_cnt;
    logic             w_load, w_advance, w_last, w_on, w_stall, w_empty;
    logic [FB_AW-1:0] w_pix_addr;
    logic             r_s1_vld, r_s1_on;
    logic [FB_AW-1:0] r_s1_addr;
    logic             r_skid_vld;
    logic [IDX_W-1:0] r_skid, w_q;

    assign w_stall   = fb_we & fb_stall;
    assign w_empty   = (cmd_w == 7'd0) | (cmd_h == 7'd0);
    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign w_q       = r_skid_vld ? r_skid : rom_q;

    blit_addr_gen u_addr_gen (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_load      (w_load),
        .i_advance   (w_advance),
        .i_x         (cmd_x),
        .i_y         (cmd_y),
        .i_w         (cmd_w),
        .i_h         (cmd_h),
        .i_base      (cmd_base),
        .o_rom_addr  (rom_addr),
        .o_fb_addr   (w_pix_addr),
        .o_on_screen (w_on),
        .o_last      (w_last)
    );

    // State register and the two-cycle drain counter; both hold while a write is stalled.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_drain_cnt <= 1'b0;
        end else if (!w_stall) begin
            r_state     <= w_next;
            r_drain_cnt <= (r_state == DRAIN) ? ~r_drain_cnt : 1'b0;
        end
    end

    // Next state, counter load and advance strobes.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (w_empty) begin
                        w_next = DONE;
                    end else begin
                        w_next = RUN;
                        w_load = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!w_stall) begin
                    if (w_last) w_next = DRAIN;
                    else        w_advance = 1'b1;
                end
            end
            DRAIN:   if (!w_stall && r_drain_cnt) w_next = DONE;
            DONE:    if (!w_stall) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Stage 1: carry the addressed pixel's on-screen flag and FB address alongside the ROM read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_on   <= 1'b0;
            r_s1_addr <= '0;
        end else if (!w_stall) begin
            r_s1_vld  <= (r_state == RUN);
            r_s1_on   <= w_on;
            r_s1_addr <= w_pix_addr;
        end
    end

    // The ROM keeps returning new data while frozen, so hold the stage-1 pixel's data from the first stall cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_skid_vld <= 1'b0;
            r_skid     <= '0;
        end else if (w_stall) begin
            if (!r_skid_vld) begin
                r_skid_vld <= 1'b1;
                r_skid     <= rom_q;
            end
        end else begin
            r_skid_vld <= 1'b0;
        end
    end

    // Stage 2: registered frame-buffer write, suppressed for clipped or transparent pixels.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else if (!w_stall) begin
            fb_we   <= r_s1_vld & r_s1_on & (w_q != TRANSP_IDX);
            fb_addr <= r_s1_addr;
            fb_data <= w_q;
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a pixel-level reference model fills the
// expected-write queue per command; a monitor pops and compares on every committed write.
module tb_sprite_blitter;
    logic        Clk;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x, cmd_y;
    logic [6:0]  cmd_w, cmd_h;
    logic [12:0] cmd_base;
    logic        busy, done;
    logic [12:0] rom_addr;
    logic [2:0]  rom_q;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_stall;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic [2:0] rom [0:8191];
    wr_t        exp_q[$];
    int         exp_lat_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int wr_cnt = 0;
    int stall_cnt = 0;
    int stall_used = 0;
    int stall_mode = 0;
    int last_lat = 0;
    int first_addr = 0;
    int last_addr = 0;
    bit done_seen = 0;
    bit prev_done = 0;

    sprite_blitter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_base  (cmd_base),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_stall  (fb_stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous sprite ROM: data follows the address by one clock.
    always @(posedge Clk) rom_q <= rom[rom_addr];

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-port back-pressure generator.
    initial begin
        fb_stall = 1'b0;
        forever begin
            @(negedge Clk);
            if (stall_mode == 1) begin
                if (fb_we && wr_cnt == 2 && stall_used < 5) begin
                    fb_stall = 1'b1;
                    stall_used++;
                end else begin
                    fb_stall = 1'b0;
                end
            end else if (stall_mode == 2) begin
                fb_stall = ($urandom_range(0, 3) == 0);
            end else begin
                fb_stall = 1'b0;
            end
        end
    end

    // Monitor: compares committed writes and done timing against the scoreboard.
    initial forever begin
        wr_t e;
        int  lat;
        @(negedge Clk);
        #2;
        if (Reset) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                check("ready_after_done", int'(cmd_ready), 1);
                check("busy_after_done", int'(busy), 0);
            end
            prev_done = done;
            if (fb_we && fb_stall) stall_cnt++;
            if (fb_we && !fb_stall) begin
                if (wr_cnt == 0) first_addr = int'(fb_addr);
                last_addr = int'(fb_addr);
                wr_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0d data %0d, no write expected", fb_addr, fb_data);
                end else begin
                    e = exp_q.pop_front();
                    check("fb_addr", int'(fb_addr), e.addr);
                    check("fb_data", int'(fb_data), e.data);
                end
            end
            if (done) begin
                check("busy_with_done", int'(busy), 1);
                n_checks++;
                if (exp_lat_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_done: done high with no command pending (cycle %0d)", cyc);
                end else begin
                    lat = cyc - acc_cyc + 1;
                    last_lat = lat;
                    check("done_latency_model", lat, exp_lat_q.pop_front() + stall_cnt);
                end
                check("writes_missing_at_done", exp_q.size(), 0);
                exp_q.delete();
                done_seen = 1'b1;
            end
        end
    end

    // Build the expected write list from the pixel rules, then hand the command over.
    task automatic start_cmd(input int x, input int y, input int w, input int h, input int base, output int n_exp);
        int  t;
        int  sx, sy, d;
        wr_t e;
        n_exp = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                sx = x + c;
                sy = y + r;
                d  = int'(rom[(base + r * w + c) % 8192]);
                if (sx < 640 && sy < 480 && d != 0) begin
                    e.addr = sy * 640 + sx;
                    e.data = d;
                    exp_q.push_back(e);
                    n_exp++;
                end
            end
        end
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge Clk);
            t++;
        end
        check("ready_before_cmd", int'(cmd_ready), 1);
        exp_lat_q.push_back((w == 0 || h == 0) ? 1 : w * h + 3);
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 7'(w);
        cmd_h     = 7'(h);
        cmd_base  = 13'(base);
        cmd_valid = 1'b1;
        @(negedge Clk);
        cmd_valid  = 1'b0;
        cmd_x      = 10'($urandom);
        cmd_y      = 10'($urandom);
        cmd_w      = 7'($urandom);
        cmd_h      = 7'($urandom);
        cmd_base   = 13'($urandom);
        acc_cyc    = cyc;
        wr_cnt     = 0;
        stall_cnt  = 0;
        stall_used = 0;
        done_seen  = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input int exp_wr);
        int t = 0;
        while (!done_seen && t < 20000) begin
            @(negedge Clk);
            t++;
        end
        check("done_timeout", int'(done_seen), 1);
        if (exp_lat >= 0) check("done_latency", last_lat, exp_lat);
        check("write_count", wr_cnt, exp_wr);
        @(negedge Clk);
        #3;
    endtask

    task automatic fill_rom(input int mode);
        for (int i = 0; i < 8192; i++) begin
            if (mode == 0)      rom[i] = 3'd1;
            else if (mode == 1) rom[i] = (i % 2 == 1) ? 3'd3 : 3'd0;
            else                rom[i] = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        int n;
        int ra;
        int rx, ry, rw, rh, rb;
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_base  = '0;
        fill_rom(0);
        repeat (3) @(negedge Clk);
        #2;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // 40x30 opaque sprite fully on-screen
        start_cmd(50, 50, 40, 30, 0, n);
        wait_done(1203, 1200);
        check("c1_first_addr", first_addr, 32050);
        check("c1_last_addr", last_addr, 50649);

        // same sprite, every other pixel transparent
        fill_rom(1);
        start_cmd(50, 50, 40, 30, 0, n);
        wait_done(1203, 600);

        // sprite clipped at the bottom-right corner
        fill_rom(0);
        start_cmd(620, 400, 50, 100, 0, n);
        wait_done(5003, 1600);

        // five-cycle stall on the third write
        stall_mode = 1;
        start_cmd(50, 50, 40, 30, 0, n);
        wait_done(1208, 1200);
        check("c4_first_addr", first_addr, 32050);
        check("c4_last_addr", last_addr, 50649);
        stall_mode = 0;

        // zero-width command
        ra = int'(rom_addr);
        start_cmd(5, 5, 0, 9, 123, n);
        wait_done(1, 0);
        check("c5_rom_addr_held", int'(rom_addr), ra);

        // reset in the middle of a run, then a small command
        start_cmd(50, 50, 40, 30, 0, n);
        repeat (100) @(negedge Clk);
        #4;
        Reset = 1'b1;
        #1;
        check("mid_rst_fb_we", int'(fb_we), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(cmd_ready), 1);
        check("mid_rst_rom_addr", int'(rom_addr), 0);
        exp_q.delete();
        exp_lat_q.delete();
        done_seen = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        start_cmd(10, 20, 2, 2, 0, n);
        wait_done(7, 4);

        // random sprites, positions, ROM contents and back-pressure
        stall_mode = 2;
        for (int i = 0; i < 12; i++) begin
            fill_rom(2);
            rx = $urandom_range(0, 700);
            ry = $urandom_range(0, 520);
            rw = $urandom_range(0, 20);
            rh = $urandom_range(0, 20);
            rb = $urandom_range(0, 8191);
            start_cmd(rx, ry, rw, rh, rb, n);
            wait_done(-1, n);
        end
        stall_mode = 0;
        repeat (3) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
